register_bank: RTL

Parametrised bank of general-purpose CPU registers that replaces the separate single-purpose A, B and instruction registers.
- Loads from the shared data bus.
- Exposes two combinational read ports to the ALU and control logic.
- Drives one selected register back onto the bus.
- Supports in-place increment/decrement of one register per cycle, with registered carry/zero flags, for stack-pointer and loop-counter use.

---
 rtl/register_bank.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// ============================================================================
// register_bank
// ----------------------------------------------------------------------------
// Parametrised bank of general-purpose CPU registers. It replaces the separate
// A, B and instruction registers with one indexed storage array.
//
// Registers load from the shared data bus. Two combinational read ports feed
// the ALU and control logic. One selected register can be driven back onto
// the bus. One register per cycle can be incremented or decremented in place,
// with registered carry/zero flags, for stack-pointer and loop-counter use.
//
// Parameters:
//   WIDTH    - data width of every register and of the bus
//   NUM_REGS - number of registers, 2..2**ADDR_W
//   ADDR_W   - width of every register-select input
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-high reset (registers and flags -> 0)
//   bus      in   data bus value to load
//   wi       in   write enable: load bus into regs[wsel]
//   wsel     in   write target index
//   inc      in   increment regs[csel]
//   dec      in   decrement regs[csel]
//   csel     in   count target index
//   rsel_a   in   read port A index
//   rsel_b   in   read port B index
//   out_a    out  regs[rsel_a], combinational
//   out_b    out  regs[rsel_b], combinational
//   oe       in   bus output enable
//   osel     in   register to drive onto the bus
//   bus_out  out  regs[osel] when oe=1, else 0 (safe to OR onto the bus)
//   bus_oe   out  copy of oe for the bus mux
//   carry    out  last count operation wrapped
//   zero     out  last count result was 0
//
// Optional feature (macro REGISTER_BANK_BYPASS_EN):
//   When defined, a read port whose index matches an in-range write returns
//   bus in the same cycle (write-to-read forwarding). Count results are never
//   forwarded. Do not enable it where bus_out can feed back into bus, because
//   that forms a combinational loop.
// ============================================================================
module register_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WIDTH-1:0]  bus,
    input  logic              wi,
    input  logic [ADDR_W-1:0] wsel,
    input  logic              inc,
    input  logic              dec,
    input  logic [ADDR_W-1:0] csel,
    input  logic [ADDR_W-1:0] rsel_a,
    input  logic [ADDR_W-1:0] rsel_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    input  logic              oe,
    input  logic [ADDR_W-1:0] osel,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_oe,
    output logic              carry,
    output logic              zero
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    logic             wr_en;
    logic             cnt_en;
    logic             cnt_apply;
    logic [WIDTH-1:0] cnt_src;
    logic [WIDTH-1:0] cnt_result;
    logic             cnt_carry;

    // Out-of-range indices decode to nothing, so they read as 0.
    function automatic logic [WIDTH-1:0] read_reg(input logic [ADDR_W-1:0] idx);
        logic [WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) begin
                result = regs[i];
            end
        end
        return result;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // A count is valid only when exactly one of inc/dec is set and the target
    // exists. A write to the same register wins and suppresses the count,
    // including its flag update.
    always_comb begin
        wr_en      = wi && in_range(wsel);
        cnt_en     = (inc ^ dec) && in_range(csel);
        cnt_apply  = cnt_en && !(wr_en && (wsel == csel));
        cnt_src    = read_reg(csel);
        cnt_result = inc ? (cnt_src + WIDTH'(1)) : (cnt_src - WIDTH'(1));
        cnt_carry  = inc ? (cnt_src == '1) : (cnt_src == '0);
    end

    // Register array: a write takes priority over a count on the same index.
    // A write and a count on different indices both take effect.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wsel == ADDR_W'(i))) begin
                    regs[i] <= bus;
                end else if (cnt_apply && (csel == ADDR_W'(i))) begin
                    regs[i] <= cnt_result;
                end
            end
        end
    end

    // Flags change only on an applied count. Otherwise they hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (cnt_apply) begin
            carry <= cnt_carry;
            zero  <= (cnt_result == '0);
        end
    end

    // Read ports. Stored registers already sit at 0 while clr is high. The
    // forwarding path is also gated by clr so that reads stay 0 during reset.
`ifdef REGISTER_BANK_BYPASS_EN
    always_comb begin
        out_a   = (!clr && wr_en && (rsel_a == wsel)) ? bus : read_reg(rsel_a);
        out_b   = (!clr && wr_en && (rsel_b == wsel)) ? bus : read_reg(rsel_b);
        bus_out = '0;
        if (oe) begin
            bus_out = (!clr && wr_en && (osel == wsel)) ? bus : read_reg(osel);
        end
    end
`else
    always_comb begin
        out_a   = read_reg(rsel_a);
        out_b   = read_reg(rsel_b);
        bus_out = oe ? read_reg(osel) : '0;
    end
`endif

    assign bus_oe = oe;

endmodule
